sc_fifo_ctrl: RTL and testbench

// Pointer/flag controller for a single-clock FIFO built on the sc_ram dual-port memory.

---
 rtl/sc_fifo_ctrl.sv | 79 +++++++
 tb/tb_sc_fifo_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sc_fifo_ctrl.sv
// sc_fifo_ctrl: pointer/flag controller driving an sc_ram dual-port memory as a single-clock FIFO
module sc_fifo_ctrl #(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 10,
  parameter int REGISTER_OUTPUT = 0,
  parameter int AFULL_LVL       = 2**AWIDTH-4,
  parameter int AEMPTY_LVL      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic              ram_wr_en_o,
  output logic [DWIDTH-1:0] ram_wr_data_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o,
  output logic              ram_rd_en_o,
  input  logic [DWIDTH-1:0] ram_rd_data_i
);
  localparam int UW = AWIDTH + 1;
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic [1:0]        rd_v_q;
  logic              wr_acc, rd_acc;
  assign wr_acc  = wrreq_i & ~full_q;
  assign rd_acc  = rdreq_i & ~empty_q;
  assign usedw_d = usedw_q + UW'(wr_acc) - UW'(rd_acc);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rd_v_q   <= '0;
    end else begin
      wr_ptr_q <= wr_acc ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
      rd_ptr_q <= rd_acc ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;
      usedw_q  <= usedw_d;
      full_q   <= usedw_d == UW'(2**AWIDTH);
      empty_q  <= usedw_d == '0;
      afull_q  <= usedw_d >= UW'(AFULL_LVL);
      aempty_q <= usedw_d <= UW'(AEMPTY_LVL);
      ovf_q    <= wrreq_i & full_q;
      unf_q    <= rdreq_i & empty_q;
      rd_v_q   <= {rd_v_q[0], rd_acc};
    end
  end
  // With a registered RAM output, mem[rd_addr] is captured every edge; rd_en then loads the output stage
  assign ram_rd_en_o    = REGISTER_OUTPUT != 0 ? rd_v_q[0] : rd_acc;
  assign q_valid_o      = REGISTER_OUTPUT != 0 ? rd_v_q[1] : rd_v_q[0];
  assign ram_rd_addr_o  = rd_ptr_q;
  assign ram_wr_addr_o  = wr_ptr_q;
  assign ram_wr_en_o    = wr_acc;
  assign ram_wr_data_o  = data_i;
  assign q_o            = ram_rd_data_i;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign usedw_o        = usedw_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
endmodule

// File: tb/tb_sc_fifo_ctrl.sv
// tb_sc_fifo_ctrl: drives unregistered- and registered-output controllers side by side against a queue model
module tb_sc_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 2**AW;
  logic clk = 0;
  logic rst_n = 0;
  logic wrreq = 0, rdreq = 0;
  logic [DW-1:0] data = '0;
  always #5 clk = ~clk;
  logic [DW-1:0] q0, q1, wd0, wd1, rdd0, rdd1, stage1;
  logic qv0, qv1, fu0, fu1, em0, em1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic we0, we1, re0, re1;
  logic [AW:0] uw0, uw1;
  logic [AW-1:0] wa0, wa1, ra0, ra1;
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  sc_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGISTER_OUTPUT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
    .q_o(q0), .q_valid_o(qv0), .full_o(fu0), .empty_o(em0), .almost_full_o(af0),
    .almost_empty_o(ae0), .usedw_o(uw0), .overflow_o(ov0), .underflow_o(un0),
    .ram_wr_addr_o(wa0), .ram_wr_en_o(we0), .ram_wr_data_o(wd0), .ram_rd_addr_o(ra0),
    .ram_rd_en_o(re0), .ram_rd_data_i(rdd0));
  sc_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .REGISTER_OUTPUT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
    .q_o(q1), .q_valid_o(qv1), .full_o(fu1), .empty_o(em1), .almost_full_o(af1),
    .almost_empty_o(ae1), .usedw_o(uw1), .overflow_o(ov1), .underflow_o(un1),
    .ram_wr_addr_o(wa1), .ram_wr_en_o(we1), .ram_wr_data_o(wd1), .ram_rd_addr_o(ra1),
    .ram_rd_en_o(re1), .ram_rd_data_i(rdd1));
  // RAM models: plain read-enabled output for dut0, sample-every-edge plus enabled output stage for dut1
  always @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0;
    if (re0) rdd0 <= mem0[ra0];
    if (we1) mem1[wa1] <= wd1;
    stage1 <= mem1[ra1];
    if (re1) rdd1 <= stage1;
  end
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] q_m[$];
  int wp = 0, rp = 0;
  bit ev0 = 0, ev1 = 0, eo = 0, eu = 0;
  logic [DW-1:0] ed0 = '0, ed1 = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    int c = q_m.size();
    check("usedw0", 64'(uw0), 64'(c));
    check("usedw1", 64'(uw1), 64'(c));
    check("full0", 64'(fu0), 64'(c == DEPTH));
    check("full1", 64'(fu1), 64'(c == DEPTH));
    check("empty0", 64'(em0), 64'(c == 0));
    check("empty1", 64'(em1), 64'(c == 0));
    check("afull0", 64'(af0), 64'(c >= DEPTH - 4));
    check("afull1", 64'(af1), 64'(c >= DEPTH - 4));
    check("aempty0", 64'(ae0), 64'(c <= 4));
    check("aempty1", 64'(ae1), 64'(c <= 4));
    check("ovf0", 64'(ov0), 64'(eo));
    check("ovf1", 64'(ov1), 64'(eo));
    check("unf0", 64'(un0), 64'(eu));
    check("unf1", 64'(un1), 64'(eu));
    check("qvalid0", 64'(qv0), 64'(ev0));
    check("qvalid1", 64'(qv1), 64'(ev1));
    if (ev0) check("q0", 64'(q0), 64'(ed0));
    if (ev1) check("q1", 64'(q1), 64'(ed1));
  endtask
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d);
    bit full_m, empty_m, wacc, racc;
    logic [DW-1:0] pd = '0;
    wrreq = wr; rdreq = rd; data = d;
    #1;
    full_m = q_m.size() == DEPTH;
    empty_m = q_m.size() == 0;
    wacc = wr && !full_m;
    racc = rd && !empty_m;
    check("wr_en0", 64'(we0), 64'(wacc));
    check("wr_en1", 64'(we1), 64'(wacc));
    check("wr_addr0", 64'(wa0), 64'(wp));
    check("wr_addr1", 64'(wa1), 64'(wp));
    check("rd_addr0", 64'(ra0), 64'(rp));
    check("rd_addr1", 64'(ra1), 64'(rp));
    check("rd_en0", 64'(re0), 64'(racc));
    check("rd_en1", 64'(re1), 64'(ev0));
    check("wr_data0", 64'(wd0), 64'(d));
    @(posedge clk);
    if (racc) begin pd = q_m.pop_front(); rp = (rp + 1) % DEPTH; end
    if (wacc) begin q_m.push_back(d); wp = (wp + 1) % DEPTH; end
    ev1 = ev0; ed1 = ed0; ev0 = racc; ed0 = pd;
    eo = wr && full_m;
    eu = rd && empty_m;
    #1;
    check_state();
  endtask
  task automatic mid_reset();
    wrreq = 0; rdreq = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    q_m.delete(); wp = 0; rp = 0;
    ev0 = 0; ev1 = 0; eo = 0; eu = 0;
    check_state();
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1;
    #1;
    step(1, 0, 16'hA); step(1, 0, 16'hB); step(1, 0, 16'hC);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 16'(16'h100 + i));
    step(1, 1, 16'h1FF);
    step(1, 0, 16'h200);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0);
    step(1, 1, 16'h300);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 16'(16'h400 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 16'(16'h500 + i));
    for (int p = 0; p < 4; p++) begin
      int pw = (p == 0) ? 80 : (p == 1) ? 20 : (p == 2) ? 50 : 65;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw + 10, 16'($urandom));
    end
    mid_reset();
    step(1, 0, 16'hD1); step(1, 0, 16'hD2);
    step(0, 1, 0);
    mid_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 16'hE1);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
